// File: rtl/piso_serializer_if.sv
// Parallel-word handshake and serial-line bundle for the PISO serializer.
// The master side is the word source and serial consumer; the slave side is
// the serializer itself.
interface piso_serializer_if #(
    parameter int WIDTH = 4
);
    logic             din_valid;
    logic [WIDTH-1:0] din;
    logic             din_ready;
    logic             dout;
    logic             dout_en;
    logic             dout_last;
    logic             busy;

    modport master (
        output din_valid,
        output din,
        input  din_ready,
        input  dout,
        input  dout_en,
        input  dout_last,
        input  busy
    );

    modport slave (
        input  din_valid,
        input  din,
        output din_ready,
        output dout,
        output dout_en,
        output dout_last,
        output busy
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter. Takes a WIDTH-bit word on a
// valid/ready handshake and sends it one bit per clock with an enable and a
// last-bit marker. A new word can be taken on the last-bit edge, so a
// continuous source keeps the line 100% busy with no idle gap.
// The interface instance must be built with the same WIDTH as this module.
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter int LSB_FIRST = 1
) (
    input logic               clk,
    input logic               clr_n,
    piso_serializer_if.slave  bus
);
    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_sreg;
    logic [WIDTH-1:0] w_sreg_nxt;
    logic [WIDTH-1:0] w_sreg_shifted;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             w_last;
    logic             w_ready;
    logic             w_accept;
    logic             w_line_bit;

    // Handshake decode: ready depends only on state and count, never on valid.
    always_comb begin
        w_last   = (r_state == SHIFT) && (r_cnt == LAST_CNT);
        w_ready  = (r_state == IDLE) || w_last;
        w_accept = bus.din_valid && w_ready;
    end

    // Shift direction and the bit currently presented to the line.
    always_comb begin
        if (LSB_FIRST != 0) begin
            w_sreg_shifted = {1'b0, r_sreg[WIDTH-1:1]};
            w_line_bit     = r_sreg[0];
        end else begin
            w_sreg_shifted = {r_sreg[WIDTH-2:0], 1'b0};
            w_line_bit     = r_sreg[WIDTH-1];
        end
    end

    // Next-state logic: load on accept, shift mid-word, clear when going idle.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned; a missed branch would otherwise infer a latch.
        w_state_nxt = r_state;
        w_sreg_nxt  = r_sreg;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (w_accept) begin
                    w_sreg_nxt  = bus.din;
                    w_state_nxt = SHIFT;
                end else begin
                    w_sreg_nxt = '0;
                end
            end
            SHIFT: begin
                if (!w_last) begin
                    w_sreg_nxt = w_sreg_shifted;
                    w_cnt_nxt  = r_cnt + 1'b1;
                end else if (w_accept) begin
                    w_sreg_nxt = bus.din;
                    w_cnt_nxt  = '0;
                end else begin
                    w_sreg_nxt  = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_sreg_nxt  = '0;
                w_cnt_nxt   = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, shift register and bit counter; reset aborts any word in flight.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= IDLE;
            r_sreg  <= '0;
            r_cnt   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, independent of statement order.
            r_state <= w_state_nxt;
            r_sreg  <= w_sreg_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Outputs: the line is forced to 0 whenever no word is being sent.
    always_comb begin
        bus.din_ready = w_ready;
        bus.dout      = (r_state == SHIFT) && w_line_bit;
        bus.dout_en   = (r_state == SHIFT);
        bus.busy      = (r_state == SHIFT);
        bus.dout_last = w_last;
    end
endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in, serial-out transmitter: accepts a WIDTH-bit word over a valid/ready handshake and drives it one bit per clock on a single serial line with an enable and last-bit marker. It is the transmit end for the 4-bit serial receive shift register, which inserts at the MSB and shifts right. With LSB_FIRST=1, that register holds the complete word after WIDTH enabled clocks. It sits between a parallel data source and any serial-in consumer on the same clock.

## Interface
Parameters:
- WIDTH, 4: word width in bits; legal range 2..32.
- LSB_FIRST, 1: 1 = bit 0 transmitted first; 0 = bit WIDTH-1 transmitted first.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- clr_n  in  1  reset; asynchronous, active-low.
- din_valid  in  1  source has a word on din.
- din  in  WIDTH  parallel word; sampled only on accept.
- din_ready  out  1  block can accept a word this cycle.
- dout  out  1  serial data bit.
- dout_en  out  1  dout carries a valid bit this cycle.
- dout_last  out  1  current dout is the final bit of the word.
- busy  out  1  a word is being transmitted.

## Operation
- FSM states: IDLE, SHIFT.
- Registers:
  - sreg[WIDTH-1:0]: shift register.
  - cnt: ceil(log2(WIDTH))-bit count of bits already sent in the current word.
- Accept condition: din_valid && din_ready at a posedge.
- din_ready is combinational:
  - 1 in IDLE;
  - 1 in SHIFT only while cnt == WIDTH-1 (last bit);
  - 0 otherwise.
- IDLE, on accept: sreg <= din, cnt <= 0, go to SHIFT.
- IDLE, no accept: remain IDLE; sreg holds 0.
- SHIFT, cnt < WIDTH-1:
  - LSB_FIRST=1: sreg shifts right, 0 fills the MSB.
  - LSB_FIRST=0: sreg shifts left, 0 fills the LSB.
  - cnt <= cnt+1.
- SHIFT, cnt == WIDTH-1, accept: sreg <= din, cnt <= 0, stay in SHIFT. Back-to-back words have no idle gap.
- SHIFT, cnt == WIDTH-1, no accept: sreg <= 0, cnt <= 0, go to IDLE.
- Outputs:
  - dout = sreg[0] (LSB_FIRST=1) or sreg[WIDTH-1] (LSB_FIRST=0), gated to 0 in IDLE.
  - dout_en = busy = (state == SHIFT).
  - dout_last = (state == SHIFT) && (cnt == WIDTH-1).
- din is ignored whenever no accept occurs; values on din outside an accept never reach dout.
- The serial line idles at 0.

## Timing
- Reset (clr_n low, asynchronous, takes effect without a clock edge):
  - state = IDLE, sreg = 0, cnt = 0.
  - Therefore dout = 0, dout_en = 0, dout_last = 0, busy = 0, din_ready = 1.
- Reset asserted mid-word aborts the word immediately. No partial remainder is sent after clr_n deasserts.
- Latency: for a word accepted at edge N, the first bit appears on dout after edge N and is valid for cycle N+1. Bit k is valid in cycle N+1+k, and dout_last is high in cycle N+WIDTH.
- A single word occupies exactly WIDTH consecutive dout_en cycles.
- Continuous stream: one word every WIDTH cycles at 100% line utilisation.
- din_valid held high while din_ready=0 stalls the source; the word is taken at the last-bit edge.
- The source may drop din_valid without acceptance. Nothing is latched.
- A valid-to-ready combinational path does not exist: din_ready depends only on state and cnt.

## Test plan
- Reset: drive clr_n=0 mid-simulation with no clock edge -> all outputs immediately at reset values; din_ready=1.
- Single word, WIDTH=4, LSB_FIRST=1, din=4'b1011 accepted at edge N -> dout = 1,1,0,1 in cycles N+1..N+4; dout_en high for exactly those 4 cycles; dout_last high only in N+4; then dout=0, busy=0.
- Back-to-back: 4'b1011 then 4'b0110 with din_valid held high -> din_ready pulses only in the last-bit cycle; dout = 1,1,0,1,0,1,1,0 with no gap; dout_last high in cycles 4 and 8.
- MSB_FIRST (LSB_FIRST=0), din=4'b1011 -> dout = 1,0,1,1.
- Abort: clr_n low during bit 2 of 4'b1111 -> dout=0, dout_en=0 at once. After release, a new word 4'b0001 transmits cleanly as 1,0,0,0.
- Loopback: serializer (LSB_FIRST=1) drives a 4-bit right-shifting receive register clocked only when dout_en=1 -> after 4 enabled clocks the receiver holds the sent word for 4'hA, 4'h5, 4'hF and 4'h0.
